// File: rtl/disp_ctrl.sv
// Display timing controller: free-running pixel/line counters with per-frame
// latched mode and enable, decoded into registered sync, active-video and VRAM read strobes.
module disp_ctrl (
  input  logic       ACLK,
  input  logic       ARST,
  input  logic [1:0] RESOL,
  input  logic       DISPON,
  output logic       VRSTART,
  output logic       BUF_RDEN,
  output logic       DSP_preDE,
  output logic       DSP_HSYNC_X,
  output logic       DSP_VSYNC_X
);

  typedef struct packed {
    logic [10:0] sync;
    logic [10:0] bp;
    logic [10:0] act;
    logic [10:0] tot;
  } axis_t;

  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic [1:0]  resol_q;
  logic        dispon_q;

  axis_t       h_tm;
  axis_t       v_tm;
  logic [10:0] h_act_start;
  logic [10:0] h_act_end;
  logic [10:0] v_act_start;
  logic [10:0] v_act_end;
  logic        h_last;
  logic        v_last;
  logic        frame_end;

  logic        hsync_n_d;
  logic        vsync_n_d;
  logic        de_d;
  logic        rden_d;
  logic        vrstart_d;

  // Mode 3 is not a real mode and falls through to 640x480.
  always_comb begin
    h_tm = '{sync: 11'd96,  bp: 11'd48,  act: 11'd640,  tot: 11'd800};
    v_tm = '{sync: 11'd2,   bp: 11'd33,  act: 11'd480,  tot: 11'd525};
    case (resol_q)
      2'd1: begin
        h_tm = '{sync: 11'd128, bp: 11'd88,  act: 11'd800,  tot: 11'd1056};
        v_tm = '{sync: 11'd4,   bp: 11'd23,  act: 11'd600,  tot: 11'd628};
      end
      2'd2: begin
        h_tm = '{sync: 11'd112, bp: 11'd248, act: 11'd1280, tot: 11'd1688};
        v_tm = '{sync: 11'd3,   bp: 11'd38,  act: 11'd1024, tot: 11'd1066};
      end
      default: ;
    endcase
  end

  always_comb begin
    h_act_start = h_tm.sync + h_tm.bp;
    h_act_end   = h_act_start + h_tm.act;
    v_act_start = v_tm.sync + v_tm.bp;
    v_act_end   = v_act_start + v_tm.act;
    h_last      = (hcnt == h_tm.tot - 11'd1);
    v_last      = (vcnt == v_tm.tot - 11'd1);
    frame_end   = h_last && v_last;
  end

  // Mode/enable are sampled together with the counter wrap, so the new frame's
  // very first cycle already decodes against the new totals.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      hcnt     <= '0;
      vcnt     <= '0;
      resol_q  <= '0;
      dispon_q <= 1'b0;
    end else begin
      if (h_last) begin
        hcnt <= '0;
        if (v_last) vcnt <= '0;
        else        vcnt <= vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 11'd1;
      end
      if (frame_end) begin
        resol_q  <= RESOL;
        dispon_q <= DISPON;
      end
    end
  end

  always_comb begin
    hsync_n_d = (hcnt >= h_tm.sync);
    vsync_n_d = (vcnt >= v_tm.sync);
    de_d      = (hcnt >= h_act_start) && (hcnt < h_act_end) &&
                (vcnt >= v_act_start) && (vcnt < v_act_end);
    rden_d    = de_d && dispon_q;
    vrstart_d = (hcnt == 11'd0) && (vcnt == 11'd0) && dispon_q;
  end

  // One register stage after the counters on every output keeps them aligned.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      VRSTART     <= 1'b0;
      BUF_RDEN    <= 1'b0;
      DSP_preDE   <= 1'b0;
      DSP_HSYNC_X <= 1'b1;
      DSP_VSYNC_X <= 1'b1;
    end else begin
      VRSTART     <= vrstart_d;
      BUF_RDEN    <= rden_d;
      DSP_preDE   <= de_d;
      DSP_HSYNC_X <= hsync_n_d;
      DSP_VSYNC_X <= vsync_n_d;
    end
  end

endmodule

// File: tb/tb_disp_ctrl.sv
// Directed bench for disp_ctrl: measures line/frame shapes from the outputs,
// fast-forwarding the counters to reach line and frame boundaries quickly.
module tb_disp_ctrl;

  logic       ACLK;
  logic       ARST;
  logic [1:0] RESOL;
  logic       DISPON;
  logic       VRSTART;
  logic       BUF_RDEN;
  logic       DSP_preDE;
  logic       DSP_HSYNC_X;
  logic       DSP_VSYNC_X;

  int n_checks = 0;
  int n_errors = 0;

  logic [10:0] jump_h;
  logic [10:0] jump_v;

  int period, hs_low, de_off, de_len, rd_off, rd_len, rd_span;

  disp_ctrl dut (
    .ACLK       (ACLK),
    .ARST       (ARST),
    .RESOL      (RESOL),
    .DISPON     (DISPON),
    .VRSTART    (VRSTART),
    .BUF_RDEN   (BUF_RDEN),
    .DSP_preDE  (DSP_preDE),
    .DSP_HSYNC_X(DSP_HSYNC_X),
    .DSP_VSYNC_X(DSP_VSYNC_X)
  );

  // clock / reset
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Skip ahead inside the current frame; the bench resyncs on output edges afterwards.
  task jump(input int h, input int v);
    @(negedge ACLK);
    jump_h = h[10:0];
    jump_v = v[10:0];
    force dut.hcnt = jump_h;
    force dut.vcnt = jump_v;
    @(negedge ACLK);
    release dut.hcnt;
    release dut.vcnt;
  endtask

  // Starts on the sample where HSYNC has just fallen; ends on the next such sample.
  task automatic measure_line();
    logic prev_hs;
    int   rd_last;
    period = 0; hs_low = 0; de_off = -1; de_len = 0;
    rd_off = -1; rd_len = 0; rd_last = -1;
    prev_hs = DSP_HSYNC_X;
    for (int i = 0; i < 2000; i++) begin
      if (i > 0 && prev_hs && !DSP_HSYNC_X) break;
      if (!DSP_HSYNC_X) hs_low++;
      if (DSP_preDE) begin
        if (de_off < 0) de_off = i;
        de_len++;
      end
      if (BUF_RDEN) begin
        if (rd_off < 0) rd_off = i;
        rd_len++;
        rd_last = i;
      end
      prev_hs = DSP_HSYNC_X;
      period++;
      @(negedge ACLK);
    end
    rd_span = (rd_off < 0) ? 0 : rd_last - rd_off + 1;
  endtask

  task automatic wait_hs_fall(input string tag, output int n_rd);
    logic prev;
    bit   ok;
    ok = 1'b0;
    n_rd = 0;
    prev = DSP_HSYNC_X;
    for (int i = 0; i < 2000; i++) begin
      @(negedge ACLK);
      if (prev && !DSP_HSYNC_X) begin
        ok = 1'b1;
        break;
      end
      if (BUF_RDEN) n_rd++;
      prev = DSP_HSYNC_X;
    end
    check_val({tag, "_found"}, ok, 1);
  endtask

  task automatic wait_vs_fall(input string tag, output int n_hf, output int n_vr);
    logic prev_hs, prev_vs;
    bit   ok;
    ok = 1'b0;
    n_hf = 0;
    n_vr = 0;
    prev_hs = DSP_HSYNC_X;
    prev_vs = DSP_VSYNC_X;
    for (int i = 0; i < 6000; i++) begin
      @(negedge ACLK);
      if (prev_vs && !DSP_VSYNC_X) begin
        ok = 1'b1;
        break;
      end
      if (prev_hs && !DSP_HSYNC_X) n_hf++;
      if (VRSTART) n_vr++;
      prev_hs = DSP_HSYNC_X;
      prev_vs = DSP_VSYNC_X;
    end
    check_val({tag, "_found"}, ok, 1);
  endtask

  task automatic count_vs_low(output int n);
    n = 0;
    for (int i = 0; i < 8000; i++) begin
      if (DSP_VSYNC_X) break;
      n++;
      @(negedge ACLK);
    end
  endtask

  initial begin
    int n_rd, n_hf, n_vr, vs_low;

    // reset state; inputs set to a non-default mode to show they are not latched
    ARST = 1'b1; RESOL = 2'd2; DISPON = 1'b1;
    repeat (3) @(negedge ACLK);
    check_val("rst_vrstart", VRSTART, 0);
    check_val("rst_rden", BUF_RDEN, 0);
    check_val("rst_de", DSP_preDE, 0);
    check_val("rst_hsync", DSP_HSYNC_X, 1);
    check_val("rst_vsync", DSP_VSYNC_X, 1);

    // first frame: mode 0, display disabled
    ARST = 1'b0; RESOL = 2'd0; DISPON = 1'b0;
    @(negedge ACLK);
    check_val("f0_hsync_start", DSP_HSYNC_X, 0);
    check_val("f0_vsync_start", DSP_VSYNC_X, 0);
    check_val("f0_vrstart", VRSTART, 0);
    count_vs_low(vs_low);
    check_val("m0_vs_low", vs_low, 1600);
    measure_line();
    check_val("m0_period", period, 800);
    check_val("m0_hs_low", hs_low, 96);
    check_val("m0_blank_de", de_len, 0);

    jump(700, 34);
    wait_hs_fall("m0_l35", n_rd);
    check_val("m0_l34_rden", n_rd, 0);
    measure_line();
    check_val("m0_act_period", period, 800);
    check_val("m0_de_off", de_off, 144);
    check_val("m0_de_len", de_len, 640);
    check_val("m0_dis_rden", rd_len, 0);

    // mid-frame change to mode 2 / enabled must not disturb this frame
    RESOL = 2'd2; DISPON = 1'b1;
    measure_line();
    check_val("m0_hold_period", period, 800);
    check_val("m0_hold_de_off", de_off, 144);
    check_val("m0_hold_rden", rd_len, 0);

    jump(100, 522);
    wait_vs_fall("m0_end", n_hf, n_vr);
    check_val("m0_tail_lines", n_hf, 2);
    check_val("m0_tail_vr", n_vr, 0);
    check_val("m2_vrstart", VRSTART, 1);
    check_val("m2_hsync_start", DSP_HSYNC_X, 0);

    // mode 2 frame
    count_vs_low(vs_low);
    check_val("m2_vs_low", vs_low, 5064);
    measure_line();
    check_val("m2_period", period, 1688);
    check_val("m2_hs_low", hs_low, 112);
    check_val("m2_blank_de", de_len, 0);

    jump(1500, 40);
    wait_hs_fall("m2_l41", n_rd);
    check_val("m2_l40_rden", n_rd, 0);
    measure_line();
    check_val("m2_de_off", de_off, 360);
    check_val("m2_de_len", de_len, 1280);
    check_val("m2_rd_off", rd_off, 360);
    check_val("m2_rd_len", rd_len, 1280);
    check_val("m2_rd_span", rd_span, 1280);

    RESOL = 2'd1;
    jump(1500, 1063);
    wait_hs_fall("m2_l1064", n_rd);
    measure_line();
    check_val("m2_last_act_rd", rd_len, 1280);
    measure_line();
    check_val("m2_last_period", period, 1688);
    check_val("m2_last_de", de_len, 0);
    check_val("m1_vsync_start", DSP_VSYNC_X, 0);
    check_val("m1_vrstart", VRSTART, 1);

    // mode 1 frame
    count_vs_low(vs_low);
    check_val("m1_vs_low", vs_low, 4224);
    measure_line();
    check_val("m1_period", period, 1056);
    check_val("m1_hs_low", hs_low, 128);

    jump(900, 26);
    wait_hs_fall("m1_l27", n_rd);
    check_val("m1_l26_rden", n_rd, 0);
    measure_line();
    check_val("m1_de_off", de_off, 216);
    check_val("m1_rd_off", rd_off, 216);
    check_val("m1_rd_len", rd_len, 800);
    check_val("m1_rd_span", rd_span, 800);

    // disable mid-frame: this frame keeps reading to the end
    DISPON = 1'b0;
    jump(900, 625);
    wait_hs_fall("m1_l626", n_rd);
    measure_line();
    check_val("m1_l626_rd", rd_len, 800);
    measure_line();
    check_val("m1_l627_rd", rd_len, 0);
    check_val("m1_l627_period", period, 1056);
    check_val("m1off_vsync_start", DSP_VSYNC_X, 0);
    check_val("m1off_vrstart", VRSTART, 0);
    measure_line();
    check_val("m1off_period", period, 1056);
    check_val("m1off_hs_low", hs_low, 128);

    jump(900, 26);
    wait_hs_fall("m1off_l27", n_rd);
    measure_line();
    check_val("m1off_de_len", de_len, 800);
    check_val("m1off_rd_len", rd_len, 0);

    // re-enable with mode 3, which must behave as mode 0
    DISPON = 1'b1; RESOL = 2'd3;
    jump(900, 626);
    wait_hs_fall("m1off_l627", n_rd);
    measure_line();
    check_val("m1off_last_period", period, 1056);
    check_val("m3_vrstart", VRSTART, 1);
    check_val("m3_vsync_start", DSP_VSYNC_X, 0);
    measure_line();
    check_val("m3_period", period, 800);
    check_val("m3_hs_low", hs_low, 96);

    // asynchronous reset during active video
    jump(700, 34);
    wait_hs_fall("m3_l35", n_rd);
    repeat (200) @(negedge ACLK);
    check_val("m3_rden_mid", BUF_RDEN, 1);
    #2 ARST = 1'b1;
    #1;
    check_val("arst_rden", BUF_RDEN, 0);
    check_val("arst_de", DSP_preDE, 0);
    check_val("arst_hsync", DSP_HSYNC_X, 1);
    check_val("arst_vsync", DSP_VSYNC_X, 1);
    check_val("arst_vrstart", VRSTART, 0);
    RESOL = 2'd2; DISPON = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    ARST = 1'b0;
    @(negedge ACLK);
    check_val("rel_hsync_start", DSP_HSYNC_X, 0);
    check_val("rel_vsync_start", DSP_VSYNC_X, 0);
    check_val("rel_vrstart", VRSTART, 0);
    measure_line();
    check_val("rel_period", period, 800);
    check_val("rel_hs_low", hs_low, 96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
